counter_v2: RTL and testbench
=============================

Name: counter_v2

Overview:
- Synchronous up/down event counter, range 0..99, for the scoreboard score display path.
- clk_up_i and clk_down_i are asynchronous event lines, e.g. debounced buttons or slow strobes. Each rising edge is one count event.
- Both event lines are synchronised into the clk_i domain and edge-detected.
- The count saturates at both limits and drives counter_val_o directly from a register.

Parameters:
- BW, 7: width of counter_val_o. Must satisfy 2**BW > MAX_VAL.
- MAX_VAL, 99: upper count limit (inclusive). Lower limit is fixed at 0.

Ports:
- clk_i  input  1  system clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- clk_up_i  input  1  asynchronous count-up event line; each rising edge increments the count by one.
- clk_down_i  input  1  asynchronous count-down event line; each rising edge decrements the count by one.
- counter_val_o  output  BW  current count, unsigned, registered.

Behaviour:
- Single clock domain clk_i. Reset is synchronous and active-high: rst_i is sampled on the clk_i rising edge.
- Reset values:
  - counter_val_o = 0
  - all synchroniser and edge-history flops = 0
  - reset has priority over any event in the same cycle.
- Synchronisation: each event line passes through a 2-flop synchroniser (s1, s2), followed by a history flop p.
- Edge detect: event = s2 & ~p, asserted for exactly one clk_i cycle per input rising edge.
- Latency: an input rising edge captured at clk_i edge N becomes visible on counter_val_o after edge N+2, i.e. 3 clk_i edges including the capture edge.
- Input timing: for a guaranteed single count, each high and each low phase of an event line must last at least 2 clk_i periods.
  - Shorter pulses may be missed.
  - A single edge never produces more than one count.
- Falling edges of either event line have no effect.
- Update rules, per clk_i edge, with up = up-event and dn = down-event:
  - up & ~dn: count+1 if count < MAX_VAL; else hold at MAX_VAL (saturate, no wrap to 0).
  - dn & ~up: count-1 if count > 0; else hold at 0 (saturate, no wrap to MAX_VAL).
  - up & dn (simultaneous): hold, net zero.
  - neither: hold.
- Arithmetic is BW-bit unsigned. Compare against MAX_VAL before incrementing; no overflow is possible.
- Reset mid-operation:
  - count returns to 0 on the reset edge.
  - Synchroniser/history flops clear, so an input already high during reset produces one event after reset release (p=0, s2 becomes 1).
- counter_val_o never leaves [0, MAX_VAL].

Decomposition:
- Shared package scoreboard_pkg:
  - constant SCORE_MAX = 99
  - constant SCORE_BW = 7
  - used as the defaults for MAX_VAL and BW.
- Sub-module edge_sync: 2-flop synchroniser plus rising-edge detector.
  - Ports: clk_i, rst_i, async_i, pulse_o.
  - Instantiated twice, once per event line.
- Top counter_v2 holds the saturating count register and the up/down arbitration.

Test Plan:
- Reset: hold rst_i=1 for 10 cycles with clk_up_i toggling -> counter_val_o stays 0. After release with clk_up_i still high, exactly one count -> 1.
- Count up: release reset, apply 50 clean up pulses (4-cycle period) -> counter_val_o = 50. The first increment appears 3 clk_i edges after the first rising edge.
- Upper saturation: from 0, apply 120 up pulses -> value reaches 99 after the 99th pulse and stays 99. Never reads 0 or 100.
- Count down and lower saturation: from 99, apply 120 down pulses -> value decreases by 1 per pulse to 0, then holds 0. Never reads 127 or 99.
- Simultaneous events: at count 40, drive identical up and down pulses 10 times -> stays 40. Then 3 up-only pulses -> 43, then 5 down-only pulses -> 38.
- Mid-operation reset: at count 75, assert rst_i for one cycle -> 0 on the next clk_i edge. Subsequent up pulses resume from 0 (2 pulses -> 2).

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the scoreboard score display path.
package scoreboard_pkg;

    localparam int SCORE_MAX = 99;
    localparam int SCORE_BW  = 7;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_INC,
        STEP_DEC
    } step_e;

    // Simultaneous up and down events cancel out.
    function automatic step_e decode_step(input logic up, input logic dn);
        if (up && !dn) begin
            return STEP_INC;
        end else if (dn && !up) begin
            return STEP_DEC;
        end
        return STEP_HOLD;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one asynchronous event line.
module edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic pulse_o
);

    logic s1;
    logic s2;
    logic p;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= async_i;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign pulse_o = s2 & ~p;

endmodule

// File: rtl/counter_v2.sv
// Saturating 0..MAX_VAL up/down event counter fed by two asynchronous event lines.
module counter_v2
    import scoreboard_pkg::*;
#(
    parameter int BW      = SCORE_BW,
    parameter int MAX_VAL = SCORE_MAX
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clk_up_i,
    input  logic          clk_down_i,
    output logic [BW-1:0] counter_val_o
);

    localparam logic [BW-1:0] MAX = BW'(MAX_VAL);

    logic  up;
    logic  dn;
    step_e step;

    edge_sync u_up_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (clk_up_i),
        .pulse_o (up)
    );

    edge_sync u_down_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (clk_down_i),
        .pulse_o (dn)
    );

    always_comb begin
        step = decode_step(up, dn);
    end

    // Limits are checked before stepping, so the register never wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            counter_val_o <= '0;
        end else begin
            unique case (step)
                STEP_INC: if (counter_val_o < MAX)  counter_val_o <= counter_val_o + BW'(1);
                STEP_DEC: if (counter_val_o != '0)  counter_val_o <= counter_val_o - BW'(1);
                default:  counter_val_o <= counter_val_o;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_v2.sv
// Randomized self-checking bench for counter_v2 against a pulse-level arithmetic model.
module tb_counter_v2;

    localparam int BW      = 7;
    localparam int MAX_VAL = 99;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          clk_up_i = 1'b0;
    logic          clk_down_i = 1'b0;
    logic [BW-1:0] counter_val_o;

    int checks = 0;
    int errors = 0;
    int ref_cnt = 0;

    counter_v2 #(
        .BW      (BW),
        .MAX_VAL (MAX_VAL)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clk_up_i      (clk_up_i),
        .clk_down_i    (clk_down_i),
        .counter_val_o (counter_val_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: each complete pulse is one event; up+down together cancel.
    function automatic int model_step(input int cnt, input bit up, input bit dn);
        if (up && !dn) return (cnt + 1 > MAX_VAL) ? MAX_VAL : cnt + 1;
        if (dn && !up) return (cnt - 1 < 0) ? 0 : cnt - 1;
        return cnt;
    endfunction

    // Drives one pulse (inputs change on falling clk edges) and checks the result.
    task automatic pulse(input string tag, input bit up, input bit dn, input int hi, input int lo);
        @(negedge clk_i);
        clk_up_i   = up;
        clk_down_i = dn;
        repeat (hi) @(negedge clk_i);
        clk_up_i   = 1'b0;
        clk_down_i = 1'b0;
        repeat (lo - 1) @(negedge clk_i);
        ref_cnt = model_step(ref_cnt, up, dn);
        check(tag, int'(counter_val_o), ref_cnt);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (cycles) @(negedge clk_i);
        rst_i = 1'b0;
        ref_cnt = 0;
        check("reset_value", int'(counter_val_o), 0);
    endtask

    initial begin
        // Reset held 10 cycles with the up line toggling every cycle.
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 10; i++) begin
            clk_up_i = ~clk_up_i;
            @(negedge clk_i);
            check("reset_hold", int'(counter_val_o), 0);
        end
        clk_up_i = 1'b1;
        rst_i    = 1'b0;
        repeat (4) @(negedge clk_i);
        ref_cnt = 1;
        check("post_reset_high_input", int'(counter_val_o), 1);
        clk_up_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("post_reset_single_count", int'(counter_val_o), 1);

        // Count up 50 from zero, first pulse checked edge by edge for latency.
        do_reset(1);
        @(negedge clk_i);
        clk_up_i = 1'b1;
        @(negedge clk_i);
        check("latency_edge_n", int'(counter_val_o), 0);
        @(negedge clk_i);
        clk_up_i = 1'b0;
        check("latency_edge_n1", int'(counter_val_o), 0);
        @(negedge clk_i);
        check("latency_edge_n2", int'(counter_val_o), 1);
        @(negedge clk_i);
        ref_cnt = 1;
        for (int i = 1; i < 50; i++) pulse("count_up", 1'b1, 1'b0, 2, 2);
        check("count_up_50", int'(counter_val_o), 50);

        // Upper saturation.
        do_reset(1);
        for (int i = 0; i < 120; i++) pulse("sat_up", 1'b1, 1'b0, 2, 2);
        check("sat_up_final", int'(counter_val_o), 99);

        // Down to zero and lower saturation.
        for (int i = 0; i < 120; i++) pulse("sat_down", 1'b0, 1'b1, 2, 2);
        check("sat_down_final", int'(counter_val_o), 0);

        // Simultaneous events at 40.
        for (int i = 0; i < 40; i++) pulse("to_40", 1'b1, 1'b0, 2, 2);
        for (int i = 0; i < 10; i++) pulse("simultaneous", 1'b1, 1'b1, 2, 2);
        check("simultaneous_hold", int'(counter_val_o), 40);
        for (int i = 0; i < 3; i++) pulse("up_after_sim", 1'b1, 1'b0, 2, 2);
        check("up_43", int'(counter_val_o), 43);
        for (int i = 0; i < 5; i++) pulse("down_after_sim", 1'b0, 1'b1, 2, 2);
        check("down_38", int'(counter_val_o), 38);

        // Mid-operation reset at 75.
        for (int i = 0; i < 37; i++) pulse("to_75", 1'b1, 1'b0, 2, 2);
        check("at_75", int'(counter_val_o), 75);
        do_reset(1);
        for (int i = 0; i < 2; i++) pulse("resume", 1'b1, 1'b0, 2, 2);
        check("resume_2", int'(counter_val_o), 2);

        // Random mix of event kinds and phase lengths.
        for (int i = 0; i < 300; i++) begin
            int  kind;
            bit  up;
            bit  dn;
            kind = int'($urandom_range(0, 9));
            up = (kind < 5) || (kind == 8);
            dn = (kind >= 5 && kind < 8) || (kind == 8);
            if (kind == 9) begin
                up = 1'b0;
                dn = 1'b0;
            end
            pulse("random", up, dn, 2 + int'($urandom_range(0, 3)), 2 + int'($urandom_range(0, 3)));
            if (int'(counter_val_o) > MAX_VAL) check("range", int'(counter_val_o), MAX_VAL);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
